// File: rtl/if_fetch_if.sv
// Fetch-unit bundle: ID-side handshake plus the byte-wide memory port.
// master = fetch unit, slave = surrounding pipeline/memory.
interface if_fetch_if;
  logic        stall_i;
  logic        jump_i;
  logic [31:0] jump_addr_i;
  logic        mem_busy_i;
  logic [7:0]  mem_din_i;
  logic [31:0] mem_a_o;
  logic        mem_rd_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  modport master (
    input  stall_i, jump_i, jump_addr_i, mem_busy_i, mem_din_i,
    output mem_a_o, mem_rd_o, pc_o, inst_o, inst_valid_o
  );

  modport slave (
    output stall_i, jump_i, jump_addr_i, mem_busy_i, mem_din_i,
    input  mem_a_o, mem_rd_o, pc_o, inst_o, inst_valid_o
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: assembles 32-bit little-endian words from an 8-bit memory port.
// Define IF_ICACHE_EN to add a 16-entry direct-mapped instruction cache.
//
// state     | meaning
// FETCH0..3 | request byte k at fetch_pc+k; hold while memory is busy
// WAIT_LAST | byte 3 on mem_din_i; publish word and pc
// HOLD      | word presented to ID until it is accepted (stall_i=0)
module if_fetch (
  input  logic       clk,
  input  logic       rst,
  if_fetch_if.master bus
);

  typedef enum logic [2:0] {
    FETCH0, FETCH1, FETCH2, FETCH3, WAIT_LAST, HOLD
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] fetch_pc;
  logic [23:0] ibuf;
  logic        pend;
  logic [1:0]  pend_k;
  logic        rd_req;
  logic [1:0]  byte_k;
  logic        hit;
  logic [31:0] hit_data;
  logic [31:0] word_full;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic        valid_q;

  assign word_full = {bus.mem_din_i, ibuf};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH0;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_req    = 1'b0;
    byte_k    = 2'd0;
    case (state)
      FETCH0: begin
        if (hit) begin
          state_nxt = HOLD;
        end else if (!bus.mem_busy_i) begin
          rd_req    = 1'b1;
          state_nxt = FETCH1;
        end
      end
      FETCH1: begin
        byte_k = 2'd1;
        if (!bus.mem_busy_i) begin
          rd_req    = 1'b1;
          state_nxt = FETCH2;
        end
      end
      FETCH2: begin
        byte_k = 2'd2;
        if (!bus.mem_busy_i) begin
          rd_req    = 1'b1;
          state_nxt = FETCH3;
        end
      end
      FETCH3: begin
        byte_k = 2'd3;
        if (!bus.mem_busy_i) begin
          rd_req    = 1'b1;
          state_nxt = WAIT_LAST;
        end
      end
      WAIT_LAST: state_nxt = HOLD;
      HOLD:      if (!bus.stall_i) state_nxt = FETCH0;
      default:   state_nxt = FETCH0;
    endcase
    if (bus.jump_i) state_nxt = FETCH0;
  end

  // Gated with rst so the request strobe drops the moment reset asserts.
  assign bus.mem_rd_o     = rd_req & rst;
  assign bus.mem_a_o      = fetch_pc + {30'd0, byte_k};
  assign bus.pc_o         = pc_q;
  assign bus.inst_o       = inst_q;
  assign bus.inst_valid_o = valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= 32'h0;
      ibuf     <= 24'h0;
      pend     <= 1'b0;
      pend_k   <= 2'd0;
      pc_q     <= 32'h0;
      inst_q   <= 32'h0;
      valid_q  <= 1'b0;
    end else begin
      pend   <= rd_req & ~bus.jump_i;
      pend_k <= byte_k;
      // A byte lands one cycle after its request, even if that cycle is a busy stall.
      if (pend && !bus.jump_i) begin
        case (pend_k)
          2'd0:    ibuf[7:0]   <= bus.mem_din_i;
          2'd1:    ibuf[15:8]  <= bus.mem_din_i;
          2'd2:    ibuf[23:16] <= bus.mem_din_i;
          default: ;
        endcase
      end
      if (bus.jump_i) begin
        fetch_pc <= bus.jump_addr_i;
        valid_q  <= 1'b0;
      end else begin
        case (state)
          FETCH0: begin
            if (hit) begin
              inst_q  <= hit_data;
              pc_q    <= fetch_pc;
              valid_q <= 1'b1;
            end
          end
          WAIT_LAST: begin
            inst_q  <= word_full;
            pc_q    <= fetch_pc;
            valid_q <= 1'b1;
          end
          HOLD: begin
            if (!bus.stall_i) begin
              fetch_pc <= fetch_pc + 32'd4;
              valid_q  <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef IF_ICACHE_EN
  logic [15:0] ic_valid;
  logic [25:0] ic_tag  [16];
  logic [31:0] ic_data [16];
  logic [3:0]  ic_idx;
  logic        ic_fill;

  assign ic_idx   = fetch_pc[5:2];
  assign hit      = (state == FETCH0) && ic_valid[ic_idx] && (ic_tag[ic_idx] == fetch_pc[31:6]);
  assign hit_data = ic_data[ic_idx];
  assign ic_fill  = (state == WAIT_LAST) && !bus.jump_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         ic_valid         <= 16'h0;
    else if (ic_fill) ic_valid[ic_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (ic_fill) begin
      ic_tag[ic_idx]  <= fetch_pc[31:6];
      ic_data[ic_idx] <= word_full;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = 32'h0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed timing scenarios, then random
// stall/busy/jump traffic scored against a program-flow model of memory.
module tb_if_fetch;

  localparam int MEM_BYTES = 8192;

  logic clk;
  logic rst;
  if_fetch_if bus();

  if_fetch dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0]  mem [MEM_BYTES];
  logic [31:0] exp_q [$];
  int          checks   = 0;
  int          failures = 0;
  int          accepted = 0;
  bit          sb_on    = 1'b0;
  logic        mreq;
  logic [31:0] maddr;
  logic [31:0] mon_pc;
  logic [31:0] jt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] r;
    logic [31:0] ai;
    r = 32'h0;
    for (int i = 0; i < 4; i++) begin
      ai = a + 32'(i);
      r[8*i +: 8] = mem[ai[12:0]];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Byte-wide memory: data for a request appears during the following cycle.
  initial begin
    bus.mem_din_i = 8'h00;
    forever begin
      @(negedge clk);
      mreq  = bus.mem_rd_o;
      maddr = bus.mem_a_o;
      @(posedge clk);
      #1;
      bus.mem_din_i = mreq ? mem[maddr[12:0]] : 8'($urandom);
    end
  end

  // Protocol monitor plus scoreboard of accepted instructions.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rd_in_reset", {31'd0, bus.mem_rd_o}, 32'd0);
    end else begin
      chk("rd_while_idle", {31'd0, bus.mem_rd_o & (bus.inst_valid_o | bus.mem_busy_i)}, 32'd0);
      if (sb_on && bus.inst_valid_o && !bus.stall_i && !bus.jump_i) begin
        if (exp_q.size() == 0) begin
          chk("sb_queue_empty", 32'd1, 32'd0);
        end else begin
          mon_pc = exp_q.pop_front();
          chk("sb_pc", bus.pc_o, mon_pc);
          chk("sb_inst", bus.inst_o, word_at(mon_pc));
          exp_q.push_back(mon_pc + 32'd4);
          accepted++;
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;

    rst = 1'b0;
    bus.stall_i = 1'b0;
    bus.jump_i = 1'b0;
    bus.jump_addr_i = 32'h0;
    bus.mem_busy_i = 1'b0;
    repeat (3) tick();
    chk("reset_rd", {31'd0, bus.mem_rd_o}, 32'd0);
    chk("reset_pc", bus.pc_o, 32'h0);
    chk("reset_inst", bus.inst_o, 32'h0);
    chk("reset_valid", {31'd0, bus.inst_valid_o}, 32'd0);

    // Plain fetch after reset release.
    rst = 1'b1;
    #1;
    chk("first_a0", bus.mem_a_o, 32'h0);
    chk("first_rd0", {31'd0, bus.mem_rd_o}, 32'd1);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("first_addr", bus.mem_a_o, 32'(k));
      chk("first_rd", {31'd0, bus.mem_rd_o}, 32'd1);
    end
    tick();
    chk("first_wait_valid", {31'd0, bus.inst_valid_o}, 32'd0);
    tick();
    chk("first_valid", {31'd0, bus.inst_valid_o}, 32'd1);
    chk("first_inst", bus.inst_o, 32'h0010_0513);
    chk("first_pc", bus.pc_o, 32'h0);
    tick();
    chk("next_addr", bus.mem_a_o, 32'h4);
    chk("next_rd", {31'd0, bus.mem_rd_o}, 32'd1);
    chk("next_valid", {31'd0, bus.inst_valid_o}, 32'd0);

    // Memory busy for three cycles while in FETCH2.
    tick();
    tick();
    bus.mem_busy_i = 1'b1;
    #1;
    chk("busy_rd", {31'd0, bus.mem_rd_o}, 32'd0);
    repeat (3) tick();
    bus.mem_busy_i = 1'b0;
    #1;
    chk("busy_resume_addr", bus.mem_a_o, 32'h6);
    chk("busy_resume_rd", {31'd0, bus.mem_rd_o}, 32'd1);
    tick();
    tick();
    chk("busy_valid_late", {31'd0, bus.inst_valid_o}, 32'd0);
    tick();
    chk("busy_valid", {31'd0, bus.inst_valid_o}, 32'd1);
    chk("busy_inst", bus.inst_o, word_at(32'h4));
    chk("busy_pc", bus.pc_o, 32'h4);

    // ID stalls for four cycles while the word is presented.
    bus.stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_valid", {31'd0, bus.inst_valid_o}, 32'd1);
      chk("stall_inst", bus.inst_o, word_at(32'h4));
      chk("stall_pc", bus.pc_o, 32'h4);
      chk("stall_rd", {31'd0, bus.mem_rd_o}, 32'd0);
    end
    bus.stall_i = 1'b0;
    tick();
    chk("unstall_addr", bus.mem_a_o, 32'h8);
    chk("unstall_rd", {31'd0, bus.mem_rd_o}, 32'd1);
    chk("unstall_valid", {31'd0, bus.inst_valid_o}, 32'd0);

    // Redirect during FETCH2.
    tick();
    tick();
    bus.jump_i = 1'b1;
    bus.jump_addr_i = 32'h0000_1000;
    tick();
    bus.jump_i = 1'b0;
    #1;
    chk("jump_addr", bus.mem_a_o, 32'h1000);
    chk("jump_rd", {31'd0, bus.mem_rd_o}, 32'd1);
    chk("jump_valid", {31'd0, bus.inst_valid_o}, 32'd0);
    repeat (5) tick();
    chk("jump_done_valid", {31'd0, bus.inst_valid_o}, 32'd1);
    chk("jump_done_pc", bus.pc_o, 32'h1000);
    chk("jump_done_inst", bus.inst_o, word_at(32'h1000));

    // Asynchronous reset in FETCH3.
    repeat (4) tick();
    chk("pre_reset_addr", bus.mem_a_o, 32'h1007);
    #2;
    rst = 1'b0;
    #1;
    chk("async_pc", bus.pc_o, 32'h0);
    chk("async_inst", bus.inst_o, 32'h0);
    chk("async_valid", {31'd0, bus.inst_valid_o}, 32'd0);
    chk("async_rd", {31'd0, bus.mem_rd_o}, 32'd0);
    tick();
    rst = 1'b1;
    #1;
    chk("post_reset_addr", bus.mem_a_o, 32'h0);
    chk("post_reset_rd", {31'd0, bus.mem_rd_o}, 32'd1);
    repeat (5) tick();
    chk("post_reset_valid", {31'd0, bus.inst_valid_o}, 32'd1);
    chk("post_reset_inst", bus.inst_o, 32'h0010_0513);

`ifdef IF_ICACHE_EN
    // Word at 0 is now cached; loop back to it twice.
    for (int p = 0; p < 2; p++) begin
      bus.jump_i = 1'b1;
      bus.jump_addr_i = 32'h0;
      tick();
      bus.jump_i = 1'b0;
      #1;
      chk("ic_hit_rd", {31'd0, bus.mem_rd_o}, 32'd0);
      tick();
      chk("ic_hit_valid", {31'd0, bus.inst_valid_o}, 32'd1);
      chk("ic_hit_pc", bus.pc_o, 32'h0);
      chk("ic_hit_inst", bus.inst_o, 32'h0010_0513);
      chk("ic_hit_rd_hold", {31'd0, bus.mem_rd_o}, 32'd0);
    end
`endif

    // Random traffic scored against the program-flow model.
    tick();
    rst = 1'b0;
    bus.stall_i = 1'b0;
    bus.mem_busy_i = 1'b0;
    bus.jump_i = 1'b0;
    exp_q.delete();
    exp_q.push_back(32'h0);
    sb_on = 1'b1;
    tick();
    rst = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      bus.stall_i = ($urandom_range(0, 3) == 0);
      bus.mem_busy_i = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 7))
          0: jt = 32'hFFFF_FFFC;
          1: begin
            jt = {19'd0, 13'($urandom_range(0, MEM_BYTES - 1))};
`ifdef IF_ICACHE_EN
            jt[1:0] = 2'b00;
`endif
          end
          default: jt = {17'd0, 13'($urandom_range(0, 2047)), 2'b00};
        endcase
        bus.jump_i = 1'b1;
        bus.jump_addr_i = jt;
        exp_q.delete();
        exp_q.push_back(jt);
      end else begin
        bus.jump_i = 1'b0;
      end
    end
    tick();
    bus.jump_i = 1'b0;
    bus.stall_i = 1'b0;
    bus.mem_busy_i = 1'b0;
    repeat (2) tick();
    sb_on = 1'b0;
    chk("sb_progress", {31'd0, accepted >= 100}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
